alu_sequencer: RTL
==================

# alu_sequencer

Single-transaction controller in front of the `ALU` datapath: accepts one calculator request per handshake, latches operands and opcode, drives the ALU enable until the ALU reports valid, then holds the widened result for the consumer. Guards the datapath against divide-by-zero and a hung ALU with a bounded timeout, flagging both through `out_err`. Sits between the keypad/command decoder and `ALU`; `ALU` is instantiated outside this block.

## Interface
- `inSize`, 4, operand width; result width is 2*inSize
- `TIMEOUT`, 64, max cycles in WAIT before abort (≥2)
- `clk` input 1 system clock, rising edge
- `rst` input 1 asynchronous, active-low reset
- `in_valid` input 1 request present
- `in_ready` output 1 sequencer can accept request
- `in_op` input 2 opcode: 00 add, 01 sub, 10 mul, 11 div
- `in_a` input inSize operand A / dividend
- `in_b` input inSize operand B / divisor
- `alu_en` output 1 to ALU `en`
- `alu_op` output 2 to ALU `operation`
- `alu_a` output inSize to ALU `A`
- `alu_b` output inSize to ALU `B`
- `alu_result` input 2*inSize from ALU `result`
- `alu_valid` input 1 from ALU `valid`
- `out_valid` output 1 result present
- `out_ready` input 1 consumer accepts result
- `out_result` output 2*inSize captured result
- `out_err` output 1 result invalid (div-by-zero or timeout)
- `busy` output 1 state ≠ IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: `in_ready`=1. On `in_valid`&`in_ready`: latch `in_op`,`in_a`,`in_b` into op/a/b registers. If op=11 and b=0 → DONE with `out_result`=all ones, `out_err`=1 (ALU never enabled). Else → ISSUE.
- ISSUE: `alu_en`=1, timer cleared to 0; `alu_valid` ignored this cycle → WAIT.
- WAIT: `alu_en`=1, timer increments each cycle. `alu_valid`=1 → capture `alu_result` into `out_result`, `out_err`=0, → DONE. Else timer = TIMEOUT-1 → `out_result`=0, `out_err`=1, → DONE. `alu_valid` wins if both same cycle.
- DONE: `out_valid`=1, `alu_en`=0; `out_result`/`out_err` stable until `out_ready`=1 → IDLE.
- `alu_op`/`alu_a`/`alu_b` driven from latched registers in all states; constant for whole transaction.
- `in_ready` only in IDLE: no request accepted while busy, no same-cycle restart from DONE.
- Result for add/sub: ALU's inSize-bit value zero-extended by ALU; sequencer captures the full 2*inSize bits unmodified.

## Timing
- Reset (async assert, sync release): state IDLE, `in_ready`=1, `alu_en`=0, `alu_op`/`alu_a`/`alu_b`=0, `out_valid`=0, `out_result`=0, `out_err`=0, `busy`=0, timer=0.
- Accept at edge 0 → ISSUE cycle 1 → WAIT from cycle 2. `alu_valid` seen in WAIT at cycle k → `out_valid` from cycle k+1.
- Div-by-zero: `out_valid` at cycle 1, `alu_en` never high.
- Timeout: `alu_en` high cycles 1..TIMEOUT, `out_valid` at cycle TIMEOUT+1 with `out_err`=1.
- `out_ready` held high: DONE lasts 1 cycle; next accept earliest cycle after return to IDLE.
- Reset mid-transaction: immediate return to IDLE, `alu_en` drops asynchronously, latched result discarded.

## Structure
- Shared package `calc_pkg`: opcode constants `OP_ADD`=00, `OP_SUB`=01, `OP_MUL`=10, `OP_DIV`=11 (same encoding as `ALU` mux order) and state encoding constants; `mux41` selection and this block both use it.
- One sub-module: `calc_timeout_ctr` (clear, enable, terminal-count flag at TIMEOUT-1, width $clog2(TIMEOUT)).

## Test plan
- Add inSize=4: a=5,b=6, ALU valid 3 cycles after ISSUE → `out_result`=11, `out_err`=0, `out_valid` one cycle after `alu_valid`; `alu_op`=00 throughout.
- Mul: a=15,b=15 → `out_result`=225 captured full 8 bits; `out_ready` low 5 cycles → result/`out_valid` stable, `in_ready`=0, second `in_valid` ignored.
- Div-by-zero: op=11,a=9,b=0 → `out_valid` next cycle, `out_result`=8'hFF, `out_err`=1, `alu_en` never asserted.
- Timeout TIMEOUT=8, `alu_valid` stuck 0 → `alu_en` high exactly 8 cycles, then `out_err`=1, `out_result`=0; `alu_valid` on final WAIT cycle instead → normal result, `out_err`=0.
- Reset asserted in WAIT (op=10) → `alu_en`, `busy`, `out_valid` 0 without clock edge; after release, div a=13,b=4 → `out_result` from ALU, `out_err`=0.
- Back-to-back with `out_ready`=1, `in_valid`=1 continuously: accepts spaced by ALU latency+3 cycles, `alu_en` low between transactions.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: ALU opcode encoding (same order as the ALU
// result mux) and the sequencer state encoding.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } seq_state_e;

  // A division whose divisor is zero is answered locally and never reaches the ALU.
  function automatic logic is_div_by_zero(input logic [1:0] op, input logic divisor_zero);
    return (op == OP_DIV) && divisor_zero;
  endfunction

endpackage

// File: rtl/calc_timeout_ctr.sv
// Bounded cycle counter guarding the ALU wait; flags terminal count TIMEOUT-1
// and saturates there until cleared.
module calc_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] TC_VAL = W'(TIMEOUT - 1);
  localparam logic [W-1:0] ONE    = W'(1);

  logic [W-1:0] count_r;

  // Count enabled cycles, saturating at the terminal value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (en && (count_r != TC_VAL)) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == TC_VAL);

endmodule

// File: rtl/alu_sequencer.sv
// Single-transaction controller in front of the ALU: latches one request, drives
// the ALU until valid (or timeout), then holds the widened result for the consumer.
module alu_sequencer
  import calc_pkg::*;
#(
  parameter int inSize  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [inSize-1:0]     in_a,
  input  logic [inSize-1:0]     in_b,
  output logic                  alu_en,
  output logic [1:0]            alu_op,
  output logic [inSize-1:0]     alu_a,
  output logic [inSize-1:0]     alu_b,
  input  logic [2*inSize-1:0]   alu_result,
  input  logic                  alu_valid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*inSize-1:0]   out_result,
  output logic                  out_err,
  output logic                  busy
);

  localparam int RW = 2 * inSize;

  seq_state_e          state_r;
  seq_state_e          state_s;
  logic [1:0]          op_r;
  logic [inSize-1:0]   a_r;
  logic [inSize-1:0]   b_r;
  logic [RW-1:0]       result_r;
  logic [RW-1:0]       result_s;
  logic                err_r;
  logic                err_s;
  logic                in_ready_r;
  logic                alu_en_r;
  logic                out_valid_r;
  logic                busy_r;
  logic                accept_s;
  logic                div0_s;
  logic                tmr_clr_s;
  logic                tmr_en_s;
  logic                tmr_tc_s;

  assign accept_s = (state_r == ST_IDLE) && in_valid;
  assign div0_s   = is_div_by_zero(in_op, (in_b == {inSize{1'b0}}));

  // Timer sits at zero outside a transaction and runs through ISSUE and WAIT,
  // so terminal count lands on the TIMEOUT-th cycle of ALU enable.
  assign tmr_clr_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
  assign tmr_en_s  = (state_r == ST_ISSUE) || (state_r == ST_WAIT);

  calc_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr_s),
    .en  (tmr_en_s),
    .tc  (tmr_tc_s)
  );

  // Next-state and next-result decode.
  always_comb begin
    state_s  = state_r;
    result_s = result_r;
    err_s    = err_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (div0_s) begin
            state_s  = ST_DONE;
            result_s = {RW{1'b1}};
            err_s    = 1'b1;
          end else begin
            state_s = ST_ISSUE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        // A valid result on the terminal cycle still counts as a good result.
        if (alu_valid) begin
          state_s  = ST_DONE;
          result_s = alu_result;
          err_s    = 1'b0;
        end else if (tmr_tc_s) begin
          state_s  = ST_DONE;
          result_s = {RW{1'b0}};
          err_s    = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, result and status flags, all registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      result_r    <= {RW{1'b0}};
      err_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      alu_en_r    <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      result_r    <= result_s;
      err_r       <= err_s;
      in_ready_r  <= (state_s == ST_IDLE);
      alu_en_r    <= (state_s == ST_ISSUE) || (state_s == ST_WAIT);
      out_valid_r <= (state_s == ST_DONE);
      busy_r      <= (state_s != ST_IDLE);
    end
  end

  // Request latch; operands stay constant for the whole transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r <= 2'b00;
      a_r  <= {inSize{1'b0}};
      b_r  <= {inSize{1'b0}};
    end else if (accept_s) begin
      op_r <= in_op;
      a_r  <= in_a;
      b_r  <= in_b;
    end else begin
      op_r <= op_r;
      a_r  <= a_r;
      b_r  <= b_r;
    end
  end

  assign in_ready   = in_ready_r;
  assign alu_en     = alu_en_r;
  assign alu_op     = op_r;
  assign alu_a      = a_r;
  assign alu_b      = b_r;
  assign out_valid  = out_valid_r;
  assign out_result = result_r;
  assign out_err    = err_r;
  assign busy       = busy_r;

endmodule
